// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_KILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;

endpackage

// File: rtl/if_redirect_sel.sv
// Redirect decode: branch beats j/jal, which beats jr; produces one target.
module if_redirect_sel
  import if_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [1:0]        i_con_jump,
  input  logic              i_con_ifbranch,
  input  logic [25:0]       i_addr_jump,
  input  logic [ADDR_W-1:0] i_addr_jumpr,
  input  logic [ADDR_W-1:0] i_addr_branch,
  output logic              o_redir_valid,
  output logic [ADDR_W-1:0] o_redir_target
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    o_redir_valid  = 1'b0;
    o_redir_target = '0;
    if (i_con_ifbranch) begin
      o_redir_valid  = 1'b1;
      o_redir_target = i_addr_branch;
    end else begin
      case (i_con_jump)
        JMP_J: begin
          o_redir_valid  = 1'b1;
          o_redir_target = {{(ADDR_W-26){1'b0}}, i_addr_jump};
        end
        JMP_JR: begin
          o_redir_valid  = 1'b1;
          o_redir_target = i_addr_jumpr;
        end
        JMP_NONE: ;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_seq.sv
// IF-stage fetch sequencer: PC, imem req/ack handshake, redirects, one-entry
// stall buffer and wrong-path kill of an in-flight request.
module if_fetch_seq
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic [1:0]        i_con_jump,
  input  logic              i_con_ifbranch,
  input  logic [25:0]       i_addr_jump,
  input  logic [ADDR_W-1:0] i_addr_jumpr,
  input  logic [ADDR_W-1:0] i_addr_branch,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic              o_flush
);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_pending;
  logic [DATA_W-1:0]   r_hold_instr;
  logic [ADDR_W-1:0]   r_hold_pc;
  logic                r_if_valid;
  logic [DATA_W-1:0]   r_instr;
  logic [ADDR_W-1:0]   r_if_pc;
  logic [ADDR_W-1:0]   r_pc_plus4;
  logic                r_flush;

  logic                w_redir_valid;
  logic [ADDR_W-1:0]   w_redir_target;
  logic [ADDR_W-1:0]   w_pc_plus4;
  logic                w_deliver_fetch;
  logic                w_deliver_hold;
  logic                w_capture;

  if_redirect_sel #(.ADDR_W(ADDR_W)) u_redirect_sel (
    .i_con_jump     (i_con_jump),
    .i_con_ifbranch (i_con_ifbranch),
    .i_addr_jump    (i_addr_jump),
    .i_addr_jumpr   (i_addr_jumpr),
    .i_addr_branch  (i_addr_branch),
    .o_redir_valid  (w_redir_valid),
    .o_redir_target (w_redir_target)
  );

  assign w_pc_plus4      = r_pc + ADDR_W'(4);
  // A redirect always wins over delivering or buffering the current instruction.
  assign w_deliver_fetch = (r_state == S_REQ)  && i_imem_ack && !w_redir_valid && !i_stall;
  assign w_capture       = (r_state == S_REQ)  && i_imem_ack && !w_redir_valid &&  i_stall;
  assign w_deliver_hold  = (r_state == S_HOLD) && !w_redir_valid && !i_stall;

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) r_state <= S_REQ;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_REQ: begin
        if (i_imem_ack) begin
          if (w_capture) w_state_next = S_HOLD;
        end else if (w_redir_valid) begin
          w_state_next = S_KILL;
        end
      end
      S_KILL:  if (i_imem_ack) w_state_next = S_REQ;
      S_HOLD:  if (w_redir_valid || !i_stall) w_state_next = S_REQ;
      default: w_state_next = S_REQ;
    endcase
  end

  always_comb begin
    o_imem_req = !i_rst && (r_state != S_HOLD);
  end

  assign o_imem_addr = r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_instr    <= '0;
      r_if_pc    <= '0;
      r_pc_plus4 <= '0;
    end else begin
      r_flush    <= w_redir_valid;
      r_if_valid <= w_deliver_fetch || w_deliver_hold;
      if (w_deliver_fetch) begin
        r_instr    <= i_imem_rdata;
        r_if_pc    <= r_pc;
        r_pc_plus4 <= w_pc_plus4;
      end else if (w_deliver_hold) begin
        r_instr    <= r_hold_instr;
        r_if_pc    <= r_hold_pc;
        r_pc_plus4 <= r_hold_pc + ADDR_W'(4);
      end
      unique case (r_state)
        S_REQ: begin
          if (i_imem_ack) r_pc <= w_redir_valid ? w_redir_target : w_pc_plus4;
        end
        S_KILL: begin
          if (i_imem_ack) r_pc <= w_redir_valid ? w_redir_target : r_pending;
        end
        S_HOLD: begin
          if (w_redir_valid) r_pc <= w_redir_target;
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  // NOTE: the hold buffer and pending target are only read in states that first write them, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (w_redir_valid) r_pending <= w_redir_target;
    if (w_capture) begin
      r_hold_instr <= i_imem_rdata;
      r_hold_pc    <= r_pc;
    end
  end

  assign o_if_valid = r_if_valid;
  assign o_instr    = r_instr;
  assign o_if_pc    = r_if_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_flush    = r_flush;

endmodule

// File: tb/tb_if_fetch_seq.sv
// Bench for if_fetch_seq: directed scenarios plus a randomized run against a
// transaction-level model (outstanding request, kill target queue, hold queue).
module tb_if_fetch_seq;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  con_jump;
  logic        ifbranch;
  logic [25:0] addr_jump;
  logic [31:0] addr_jumpr;
  logic [31:0] addr_branch;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] instr;
  logic [31:0] if_pc;
  logic [31:0] pc_plus4;
  logic        flush;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  if_fetch_seq #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall        (stall),
    .i_con_jump     (con_jump),
    .i_con_ifbranch (ifbranch),
    .i_addr_jump    (addr_jump),
    .i_addr_jumpr   (addr_jumpr),
    .i_addr_branch  (addr_branch),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_ack     (imem_ack),
    .i_imem_rdata   (imem_rdata),
    .o_if_valid     (if_valid),
    .o_instr        (instr),
    .o_if_pc        (if_pc),
    .o_pc_plus4     (pc_plus4),
    .o_flush        (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    rst         = 1'b0;
    stall       = 1'b0;
    con_jump    = 2'b00;
    ifbranch    = 1'b0;
    addr_jump   = '0;
    addr_jumpr  = '0;
    addr_branch = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", flush); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_pc_plus4: got %h want 0", pc_plus4); end
    tick();
    idle_inputs();
    settle();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
    total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL post_reset_addr: got %h want %h", imem_addr, RST_PC); end
  endtask

  task automatic test_seq_fetch;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = RST_PC + 32'(4 * i);
      total++; if (imem_addr !== a) begin bad++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, a); end
      imem_ack   = 1'b1;
      imem_rdata = mem_word(a);
      tick();
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d: got %b want 1", i, if_valid); end
      total++; if (if_pc !== a) begin bad++; $display("FAIL seq_if_pc%0d: got %h want %h", i, if_pc, a); end
      total++; if (instr !== mem_word(a)) begin bad++; $display("FAIL seq_instr%0d: got %h want %h", i, instr, mem_word(a)); end
      total++; if (pc_plus4 !== a + 32'd4) begin bad++; $display("FAIL seq_plus4%0d: got %h want %h", i, pc_plus4, a + 32'd4); end
    end
    imem_ack = 1'b0;
    tick();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL seq_idle_valid: got %b want 0", if_valid); end
  endtask

  task automatic test_stall_hold;
    ifbranch    = 1'b1;
    addr_branch = 32'h200;
    imem_ack    = 1'b1;
    tick();
    ifbranch = 1'b0;
    imem_ack = 1'b0;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL hold_setup_flush: got %b want 1", flush); end
    total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL hold_setup_addr: got %h want 200", imem_addr); end
    stall      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = mem_word(32'h200);
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req%0d: got %b want 0", i, imem_req); end
      tick();
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL hold_valid%0d: got %b want 0", i, if_valid); end
    end
    stall = 1'b0;
    tick();
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL hold_release_valid: got %b want 1", if_valid); end
    total++; if (if_pc !== 32'h200) begin bad++; $display("FAIL hold_release_pc: got %h want 200", if_pc); end
    total++; if (instr !== mem_word(32'h200)) begin bad++; $display("FAIL hold_release_instr: got %h want %h", instr, mem_word(32'h200)); end
    total++; if (imem_addr !== 32'h204) begin bad++; $display("FAIL hold_next_addr: got %h want 204", imem_addr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL hold_next_req: got %b want 1", imem_req); end
  endtask

  task automatic test_kill;
    con_jump  = 2'b01;
    addr_jump = 26'h40;
    tick();
    con_jump = 2'b00;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL kill_flush: got %b want 1", flush); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL kill_valid: got %b want 0", if_valid); end
    total++; if (imem_addr !== 32'h204) begin bad++; $display("FAIL kill_addr_held: got %h want 204", imem_addr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL kill_req: got %b want 1", imem_req); end
    tick();
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL kill_flush_once: got %b want 0", flush); end
    total++; if (imem_addr !== 32'h204) begin bad++; $display("FAIL kill_addr_held2: got %h want 204", imem_addr); end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL kill_drop_valid: got %b want 0", if_valid); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL kill_target_addr: got %h want 40", imem_addr); end
    con_jump  = 2'b01;
    addr_jump = 26'h80;
    tick();
    con_jump   = 2'b10;
    addr_jumpr = 32'h600;
    tick();
    con_jump = 2'b00;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL kill_reflush: got %b want 1", flush); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL kill_readdr_held: got %h want 40", imem_addr); end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    total++; if (imem_addr !== 32'h600) begin bad++; $display("FAIL kill_newest_addr: got %h want 600", imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL kill_newest_valid: got %b want 0", if_valid); end
  endtask

  task automatic test_priority;
    ifbranch    = 1'b1;
    con_jump    = 2'b10;
    addr_branch = 32'h300;
    addr_jumpr  = 32'h500;
    imem_ack    = 1'b1;
    tick();
    idle_inputs();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL prio_flush: got %b want 1", flush); end
    total++; if (imem_addr !== 32'h300) begin bad++; $display("FAIL prio_addr: got %h want 300", imem_addr); end
    con_jump   = 2'b11;
    addr_jumpr = 32'h500;
    addr_jump  = 26'h99;
    imem_ack   = 1'b1;
    imem_rdata = mem_word(32'h300);
    tick();
    idle_inputs();
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL prio_none_flush: got %b want 0", flush); end
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL prio_none_valid: got %b want 1", if_valid); end
    total++; if (imem_addr !== 32'h304) begin bad++; $display("FAIL prio_none_addr: got %h want 304", imem_addr); end
  endtask

  task automatic test_wrap;
    ifbranch    = 1'b1;
    addr_branch = 32'hFFFF_FFFC;
    imem_ack    = 1'b1;
    tick();
    ifbranch = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup_addr: got %h want fffffffc", imem_addr); end
    imem_rdata = mem_word(32'hFFFF_FFFC);
    tick();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %b want 1", if_valid); end
    total++; if (if_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_if_pc: got %h want fffffffc", if_pc); end
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4: got %h want 0", pc_plus4); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_reset_in_kill;
    con_jump   = 2'b10;
    addr_jumpr = 32'h700;
    tick();
    con_jump = 2'b00;
    rst      = 1'b1;
    imem_ack = 1'b1;
    settle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rstkill_req: got %b want 0", imem_req); end
    tick();
    idle_inputs();
    settle();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rstkill_valid: got %b want 0", if_valid); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rstkill_flush: got %b want 0", flush); end
    total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rstkill_addr: got %h want %h", imem_addr, RST_PC); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rstkill_req_after: got %b want 1", imem_req); end
  endtask

  task automatic test_random;
    item_t       hold_q[$];
    logic [31:0] kill_q[$];
    item_t       it;
    logic [31:0] m_pc;
    logic        m_req, redir;
    logic [31:0] tgt;
    logic        e_valid, e_flush;
    logic [31:0] e_instr, e_pc, e_p4;
    int          r;

    idle_inputs();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    m_pc    = RST_PC;
    e_valid = 1'b0; e_flush = 1'b0;
    e_instr = '0;   e_pc    = '0;   e_p4 = '0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst         = ($urandom_range(0, 199) == 0);
      stall       = ($urandom_range(0, 2) == 0);
      ifbranch    = ($urandom_range(0, 9) == 0);
      r           = $urandom_range(0, 15);
      con_jump    = (r < 2) ? 2'b01 : (r < 4) ? 2'b10 : (r == 4) ? 2'b11 : 2'b00;
      addr_jump   = 26'($urandom);
      addr_jumpr  = $urandom;
      addr_branch = $urandom;
      imem_rdata  = $urandom;
      imem_ack    = (hold_q.size() == 0) && ($urandom_range(0, 1) == 1);
      settle();

      m_req = !rst && (hold_q.size() == 0);
      total++; if (imem_req !== m_req) begin bad++; $display("FAIL rnd_req c%0d: got %b want %b", cyc, imem_req, m_req); end
      if (m_req) begin
        total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, imem_addr, m_pc); end
      end

      redir = ifbranch || (con_jump == 2'b01) || (con_jump == 2'b10);
      tgt   = ifbranch ? addr_branch : (con_jump == 2'b01) ? {6'b0, addr_jump} : addr_jumpr;

      if (rst) begin
        hold_q.delete();
        kill_q.delete();
        m_pc    = RST_PC;
        e_valid = 1'b0; e_flush = 1'b0;
        e_instr = '0;   e_pc    = '0;   e_p4 = '0;
      end else begin
        e_flush = redir;
        e_valid = 1'b0;
        if (hold_q.size() != 0) begin
          if (redir) begin
            hold_q.delete();
            m_pc = tgt;
          end else if (!stall) begin
            it      = hold_q.pop_front();
            e_valid = 1'b1;
            e_instr = it.instr;
            e_pc    = it.pc;
            e_p4    = it.pc + 32'd4;
          end
        end else if (kill_q.size() != 0) begin
          if (redir) kill_q[0] = tgt;
          if (imem_ack) m_pc = kill_q.pop_front();
        end else if (imem_ack) begin
          if (redir) begin
            m_pc = tgt;
          end else if (!stall) begin
            e_valid = 1'b1;
            e_instr = imem_rdata;
            e_pc    = m_pc;
            e_p4    = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
          end else begin
            it.pc    = m_pc;
            it.instr = imem_rdata;
            hold_q.push_back(it);
            m_pc = m_pc + 32'd4;
          end
        end else if (redir) begin
          kill_q.push_back(tgt);
        end
      end

      tick();
      total++; if (if_valid !== e_valid) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, if_valid, e_valid); end
      total++; if (flush !== e_flush) begin bad++; $display("FAIL rnd_flush c%0d: got %b want %b", cyc, flush, e_flush); end
      total++; if (instr !== e_instr) begin bad++; $display("FAIL rnd_instr c%0d: got %h want %h", cyc, instr, e_instr); end
      total++; if (if_pc !== e_pc) begin bad++; $display("FAIL rnd_if_pc c%0d: got %h want %h", cyc, if_pc, e_pc); end
      total++; if (pc_plus4 !== e_p4) begin bad++; $display("FAIL rnd_plus4 c%0d: got %h want %h", cyc, pc_plus4, e_p4); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_seq_fetch();
    test_stall_hold();
    test_kill();
    test_priority();
    test_wrap();
    test_reset_in_kill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
